// File: rtl/kgp_mem_arbiter_pkg.sv
// Shared definitions for the KGP-RISC memory arbiter.
// Holds the requester/owner encoding, the requester index map and the
// default address/data widths that the core and memory wrapper also use.
package kgp_mem_arbiter_pkg;

    // Default word-address and data widths of the KGP-RISC memory.
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_DATA_W = 32;

    // Number of requesters sharing the memory port.
    localparam int unsigned N_REQ = 2;

    // Bit positions of each requester in the arbiter req/gnt vectors.
    localparam int unsigned IDX_IF = 0;
    localparam int unsigned IDX_LS = 1;

    // Owner of a grant or of an outstanding read response.
    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/kgp_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   req[1:0]   requests, bit 0 = IF, bit 1 = LS
//   gnt[1:0]   one-hot (or zero) grant, combinational from req and last owner
// The requester that did not win last time has priority under conflict.
// Reset makes LS the last owner, so IF wins the first conflict.
module kgp_mem_arbiter_rr_arb2
    import kgp_mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt
);

    owner_e last_owner;

    // Grant decision: a lone requester wins, a conflict goes to the non-last owner.
    always_comb begin
        gnt = '0;
        if (req[IDX_IF] && (!req[IDX_LS] || (last_owner == OWNER_LS))) begin
            gnt[IDX_IF] = 1'b1;
        end else if (req[IDX_LS]) begin
            gnt[IDX_LS] = 1'b1;
        end
    end

    // Last-owner tracking; holds its value through idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= OWNER_LS;
        end else if (gnt[IDX_IF]) begin
            last_owner <= OWNER_IF;
        end else if (gnt[IDX_LS]) begin
            last_owner <= OWNER_LS;
        end
    end

endmodule

// File: rtl/kgp_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (LS).
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   if_req/if_addr               fetch request (held until granted)
//   if_gnt/if_rvalid/if_rdata    fetch grant, read-valid pulse, read data
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request (held until granted)
//   ls_gnt/ls_rvalid/ls_rdata    load/store grant, read-valid pulse, read data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory macro port (1-cycle read)
//   stall                        some request is waiting this cycle
// Grants are combinational (zero latency); read data returns one cycle after
// the grant and is steered to the requester recorded with the access.
module kgp_mem_arbiter
    import kgp_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall
);

    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] arb_gnt;
    logic             resp_valid;
    owner_e           resp_owner;

    // Requests are masked while reset is held so no grant can leak out.
    assign arb_req[IDX_IF] = if_req & rst;
    assign arb_req[IDX_LS] = ls_req & rst;

    kgp_mem_arbiter_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (arb_req),
        .gnt (arb_gnt)
    );

    assign if_gnt = arb_gnt[IDX_IF];
    assign ls_gnt = arb_gnt[IDX_LS];

    // Memory port mux from the granted requester; IF never writes.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ls_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
        end
    end

    // Outstanding read tracking; stores and idle cycles produce no response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_owner <= OWNER_IF;
        end else begin
            resp_valid <= mem_en & ~mem_we;
            resp_owner <= ls_gnt ? OWNER_LS : OWNER_IF;
        end
    end

    // Response steering; the async clear of resp_valid drops a pending read.
    assign if_rvalid = resp_valid & (resp_owner == OWNER_IF);
    assign ls_rvalid = resp_valid & (resp_owner == OWNER_LS);

    // Both ports see the memory data; rvalid qualifies it.
    assign if_rdata = rst ? mem_rdata : '0;
    assign ls_rdata = rst ? mem_rdata : '0;

    // Any request left ungranted this cycle holds the core.
    assign stall = rst & ((if_req & ~if_gnt) | (ls_req & ~ls_gnt));

endmodule
